sort_frame_ctrl: RTL and testbench

//  Sequencer for the `sort` network (NUM_VALS x SIZE, packed in/out, median).
//  - Collects NUM_VALS samples, one per beat, from a valid/ready stream.
//  - Presents them as one packed vector to `sort` and holds it stable for the sort latency.
//  - Captures the sorted vector and median, and returns them on a valid/ready result port.
//  - Sits between the sample source and `sort`; sort_median_top wires the two together.

---
 rtl/sort_pkg.sv | 18 +
 rtl/sort_sample_packer.sv | 38 +++
 rtl/sort_frame_ctrl.sv | 122 ++++++++++++
 tb/tb_sort_frame_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types and defaults for the sort network, its frame controller and the top wrapper.
package sort_pkg;

   localparam int NUM_VALS_DEF = 9;
   localparam int SIZE_DEF     = 8;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } state_e;

   // Width of a down-counter that must hold values 0..lat; never narrower than one bit.
   function automatic int lat_width(input int lat);
      return (lat > 0) ? $clog2(lat + 1) : 1;
   endfunction

endpackage

// File: rtl/sort_sample_packer.sv
// Indexed slot writer: places each accepted sample into the next slot of the packed frame.
module sort_sample_packer
   import sort_pkg::*;
#(
   parameter int NUM_VALS = NUM_VALS_DEF,
   parameter int SIZE     = SIZE_DEF,
   localparam int CNT_W   = $clog2(NUM_VALS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     wr_en,
   input  logic [SIZE-1:0]          wr_data,
   output logic [NUM_VALS*SIZE-1:0] fill_reg,
   output logic [CNT_W-1:0]         fill_cnt,
   output logic                     last_slot
);

   // The next write completes the frame; the controller uses it to leave FILL.
   assign last_slot = (fill_cnt == CNT_W'(NUM_VALS - 1));

   // Slot 0 is the most significant slot; unwritten slots keep their previous contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         fill_reg <= '0;
         fill_cnt <= '0;
      end else if (clr) begin
         fill_cnt <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < NUM_VALS; i++) begin
            if (fill_cnt == CNT_W'(i))
               fill_reg[(NUM_VALS-1-i)*SIZE +: SIZE] <= wr_data;
         end
         fill_cnt <= last_slot ? '0 : fill_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/sort_frame_ctrl.sv
// Frame sequencer around the sort network: fill a frame, wait out the sort latency,
// hand the sorted vector and median out on a valid/ready port.
//
//  state | meaning
//  FILL  | accepting samples into the fill register
//  WAIT  | frame complete, sort_in held, counting down the sort latency
//  HOLD  | result captured, m_valid high until accepted
module sort_frame_ctrl
   import sort_pkg::*;
#(
   parameter int NUM_VALS = NUM_VALS_DEF,
   parameter int SIZE     = SIZE_DEF,
   parameter int SORT_LAT = 0,
   parameter int ID_W     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [SIZE-1:0]          s_data,
   output logic [NUM_VALS*SIZE-1:0] sort_in,
   input  logic [NUM_VALS*SIZE-1:0] sort_out,
   input  logic [SIZE-1:0]          sort_median,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [NUM_VALS*SIZE-1:0] m_sorted,
   output logic [SIZE-1:0]          m_median,
   output logic [ID_W-1:0]          m_frame_id,
   output logic                     busy
);

   localparam int CNT_W = $clog2(NUM_VALS);
   localparam int LAT_W = lat_width(SORT_LAT);

   state_e             state, state_nxt;
   logic [CNT_W-1:0]   fill_cnt;
   logic [LAT_W-1:0]   lat_cnt;
   logic [ID_W-1:0]    frame_id;
   logic               last_slot;
   logic               accept, capture, deliver;

   sort_sample_packer #(
      .NUM_VALS (NUM_VALS),
      .SIZE     (SIZE)
   ) u_packer (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .wr_en     (accept),
      .wr_data   (s_data),
      .fill_reg  (sort_in),
      .fill_cnt  (fill_cnt),
      .last_slot (last_slot)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= FILL;
      else     state <= state_nxt;
   end

   // Next state and handshake decode; flush overrides every transition and drops the beat.
   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      accept    = 1'b0;
      capture   = 1'b0;
      deliver   = 1'b0;
      case (state)
         FILL: begin
            s_ready = 1'b1;
            accept  = s_valid && !flush;
            if (accept && last_slot) state_nxt = WAIT;
         end
         WAIT: begin
            if (lat_cnt == '0) begin
               capture   = !flush;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            deliver = m_ready && !flush;
            if (deliver) state_nxt = FILL;
         end
         default: state_nxt = FILL;
      endcase
      if (flush) state_nxt = FILL;
   end

   // Latency counter, result capture and frame numbering.
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_cnt  <= '0;
         m_sorted <= '0;
         m_median <= '0;
         m_valid  <= 1'b0;
         frame_id <= '0;
      end else if (flush) begin
         lat_cnt <= '0;
         m_valid <= 1'b0;
      end else begin
         if (accept && last_slot)
            lat_cnt <= LAT_W'(SORT_LAT);
         else if (state == WAIT && lat_cnt != '0)
            lat_cnt <= lat_cnt - LAT_W'(1);
         if (capture) begin
            m_sorted <= sort_out;
            m_median <= sort_median;
            m_valid  <= 1'b1;
         end
         if (deliver) begin
            m_valid  <= 1'b0;
            frame_id <= frame_id + ID_W'(1);
         end
      end
   end

   assign m_frame_id = frame_id;
   assign busy       = (state != FILL) || (fill_cnt != '0);

endmodule

// File: tb/tb_sort_frame_ctrl.sv
// Directed bench for sort_frame_ctrl with a behavioural sort behind a two-stage delay.
module tb_sort_frame_ctrl;

   localparam int NV  = 9;
   localparam int SZ  = 8;
   localparam int LAT = 2;
   localparam int IDW = 8;

   logic              clk = 1'b0;
   logic              rst, flush, s_valid, s_ready, m_valid, m_ready, busy;
   logic [SZ-1:0]     s_data, sort_median, m_median;
   logic [NV*SZ-1:0]  sort_in, sort_out, m_sorted, d1, d2;
   logic [IDW-1:0]    m_frame_id;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sort_frame_ctrl #(
      .NUM_VALS (NV),
      .SIZE     (SZ),
      .SORT_LAT (LAT),
      .ID_W     (IDW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .sort_in     (sort_in),
      .sort_out    (sort_out),
      .sort_median (sort_median),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_sorted    (m_sorted),
      .m_median    (m_median),
      .m_frame_id  (m_frame_id),
      .busy        (busy)
   );

   // Ascending sort, smallest value in the most significant slot.
   function automatic logic [NV*SZ-1:0] sort_model(input logic [NV*SZ-1:0] v);
      logic [SZ-1:0] a [NV];
      logic [SZ-1:0] t;
      logic [NV*SZ-1:0] r;
      for (int i = 0; i < NV; i++) a[i] = v[(NV-1-i)*SZ +: SZ];
      for (int i = 0; i < NV; i++)
         for (int j = 0; j < NV-1-i; j++)
            if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
      r = '0;
      for (int i = 0; i < NV; i++) r[(NV-1-i)*SZ +: SZ] = a[i];
      return r;
   endfunction

   always @(posedge clk) begin
      d1 <= sort_model(sort_in);
      d2 <= d1;
   end
   assign sort_out    = d2;
   assign sort_median = d2[(NV-1-NV/2)*SZ +: SZ];

   task automatic chk(input string name, input logic [NV*SZ-1:0] act, input logic [NV*SZ-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer the nine samples of s (first sample in the MS slot); optional idle beat between samples.
   task automatic feed(input logic [NV*SZ-1:0] s, input bit gappy);
      int n;
      for (int i = 0; i < NV; i++) begin
         s_valid = 1'b1;
         s_data  = s[(NV-1-i)*SZ +: SZ];
         n = 0;
         while (!s_ready && n < 50) begin step(); n++; end
         if (n >= 50) begin
            checks++; errors++;
            $display("FAIL feed_timeout: s_ready low for %0d cycles, want high", n);
         end
         step();
         s_valid = 1'b0;
         if (gappy && i < NV-1) begin
            s_data = 8'hEE;
            step();
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!m_valid && n < 30) begin step(); n++; end
   endtask

   typedef struct {
      logic [NV*SZ-1:0] s;
      bit               gappy;
      bit               pre_flush;
      int               hold;
      logic [NV*SZ-1:0] exp_sorted;
      logic [SZ-1:0]    exp_med;
      logic [IDW-1:0]   exp_id;
   } vec_t;

   vec_t tbl [4];

   initial begin
      int n;
      bit stable;
      logic [NV*SZ-1:0] ref_s;

      tbl[0] = '{72'h050109030702080604, 1'b0, 1'b0, 10, 72'h010203040506070809, 8'd5,  8'd0};
      tbl[1] = '{72'h050109030702080604, 1'b1, 1'b0, 0,  72'h010203040506070809, 8'd5,  8'd1};
      tbl[2] = '{72'h070707070707070707, 1'b1, 1'b0, 0,  72'h070707070707070707, 8'd7,  8'd2};
      tbl[3] = '{72'h0a141e28323c46505a, 1'b0, 1'b1, 0,  72'h0a141e28323c46505a, 8'd50, 8'd3};

      rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      chk("rst_m_valid", 72'(m_valid), 72'd0);
      chk("rst_m_median", 72'(m_median), 72'd0);
      chk("rst_busy", 72'(busy), 72'd0);
      chk("rst_s_ready", 72'(s_ready), 72'd1);
      chk("rst_sort_in", sort_in, 72'd0);

      for (int k = 0; k < 4; k++) begin
         if (tbl[k].pre_flush) begin
            feed(72'h010203040000000000, 1'b0);
            chk("preflush_busy", 72'(busy), 72'd1);
            flush = 1'b1; s_valid = 1'b1; s_data = 8'd99;
            step();
            flush = 1'b0; s_valid = 1'b0;
            chk("flush_busy", 72'(busy), 72'd0);
         end
         m_ready = (tbl[k].hold == 0);
         feed(tbl[k].s, tbl[k].gappy);
         chk("sort_in", sort_in, tbl[k].s);
         wait_valid(n);
         chk("latency", 72'(n), 72'd3);
         chk("m_sorted", m_sorted, tbl[k].exp_sorted);
         chk("m_median", 72'(m_median), 72'(tbl[k].exp_med));
         chk("m_frame_id", 72'(m_frame_id), 72'(tbl[k].exp_id));
         if (tbl[k].hold > 0) begin
            stable = 1'b1;
            for (int c = 0; c < tbl[k].hold; c++) begin
               step();
               if (!m_valid || s_ready || m_sorted !== tbl[k].exp_sorted || m_median !== tbl[k].exp_med)
                  stable = 1'b0;
            end
            chk("hold_stable", 72'(stable), 72'd1);
            m_ready = 1'b1;
         end
         step();
         m_ready = 1'b0;
         chk("post_m_valid", 72'(m_valid), 72'd0);
         chk("post_s_ready", 72'(s_ready), 72'd1);
         chk("post_frame_id", 72'(m_frame_id), 72'(tbl[k].exp_id + 8'd1));
      end

      // flush together with m_ready in HOLD: frame dropped, id unchanged, results kept
      feed(72'h090807060504030201, 1'b0);
      wait_valid(n);
      chk("fhold_valid", 72'(m_valid), 72'd1);
      flush = 1'b1; m_ready = 1'b1;
      step();
      flush = 1'b0; m_ready = 1'b0;
      chk("fhold_m_valid", 72'(m_valid), 72'd0);
      chk("fhold_frame_id", 72'(m_frame_id), 72'd4);
      chk("fhold_m_sorted", m_sorted, 72'h010203040506070809);
      chk("fhold_busy", 72'(busy), 72'd0);

      // reset for one cycle during WAIT
      ref_s = 72'h112233445566778899;
      feed(ref_s, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      stable = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (m_valid) stable = 1'b0;
         step();
      end
      chk("rstwait_no_valid", 72'(stable), 72'd1);
      chk("rstwait_frame_id", 72'(m_frame_id), 72'd0);
      chk("rstwait_sort_in", sort_in, 72'd0);
      chk("rstwait_m_sorted", m_sorted, 72'd0);
      chk("rstwait_m_median", 72'(m_median), 72'd0);
      chk("rstwait_busy", 72'(busy), 72'd0);
      chk("rstwait_s_ready", 72'(s_ready), 72'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
